// File: rtl/sync_fifo_pkg.sv
// Shared helpers for sync_fifo_param: address-width calculation and
// parameter legality check evaluated at elaboration.
package sync_fifo_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // DEPTH must be a power of two >= 2; thresholds must fall inside 1..DEPTH / 0..DEPTH-1.
  function automatic bit params_legal(input int unsigned depth,
                                      input int unsigned af,
                                      input int unsigned ae);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (af >= 1) && (af <= depth) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
module sync_fifo_mem #(
  parameter int unsigned WIDTH = 27,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised first-word-fall-through synchronous FIFO with level, almost flags and flush.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter  int unsigned WIDTH     = 27,
  parameter  int unsigned DEPTH     = 32,
  parameter  int unsigned AF_THRESH = DEPTH - 2,
  parameter  int unsigned AE_THRESH = 1,
  localparam int unsigned AW        = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      level
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  if (!params_legal(DEPTH, AF_THRESH, AE_THRESH)) begin : g_param_check
    $error("sync_fifo_param: illegal DEPTH or threshold parameters");
  end

  localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];
  localparam logic [AW:0] AF_L    = AF_THRESH[AW:0];
  localparam logic [AW:0] AE_L    = AE_THRESH[AW:0];

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] rdata;
  logic             rd_acc, wr_acc;

  assign empty        = (level == '0);
  assign full         = (level == DEPTH_L);
  assign almost_full  = (level >= AF_L);
  assign almost_empty = (level <= AE_L);

  assign rd_acc = rd_en & ~empty;
  // At full a write is still taken when paired with a read, since the read frees the slot.
  assign wr_acc = wr_en & (~full | rd_en);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      if (wr_acc && !rd_acc)      level <= level + (AW+1)'(1);
      else if (rd_acc && !wr_acc) level <= level - (AW+1)'(1);
    end
  end

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc & ~flush),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign dout = empty ? '0 : rdata;

`ifdef SYNC_FIFO_ERR_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !wr_acc)            overflow  <= 1'b1;
      if (rd_en && empty && !wr_en)    underflow <= 1'b1;
    end
  end
`endif

endmodule
